pipelined_carry_select_add_sub: RTL
===================================

Name: pipelined_carry_select_add_sub

Overview:
Parametrised, pipelined two's-complement adder/subtractor built from R-bit carry-select blocks, split into P register-separated slices. It is the next generation of the combinational carry-skip/carry-select add/sub units. It adds a valid/ready streaming interface, registered carry hand-off between slices and a configurable pipeline depth. It sits in the ALU datapath wherever M-bit add/sub throughput of one operation per clock is needed at a higher clock rate than a single-cycle adder allows.

Parameters:
M, 32, operand/result width in bits
R, 4, carry-select block width; M must be divisible by P*R
P, 4, pipeline slices = latency in cycles; 1 <= P <= M/R

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
sub  input  1  0: add, 1: subtract
cin  input  1  add: carry-in; sub: borrow-in
x  input  M  operand A, signed
y  input  M  operand B, signed
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
out  output  M  result
cout  output  1  carry-out (sub: 1 = no borrow)
v  output  1  signed overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Arithmetic:
  - sub=0: {cout,out} = x + y + cin.
  - sub=1: {cout,out} = x + ~y + ~cin, i.e. x - y - cin.
  - v = (a[M-1]==b[M-1]) && (out[M-1]!=a[M-1]), with a=x and b = sub ? ~y : y.
- Slicing:
  - Slice k (0..P-1) computes bits [(k+1)*M/P-1 : k*M/P].
  - Each slice uses carry-select blocks of R bits: each block forms sum0 and sum1 and muxes on the incoming carry.
  - Slice k's carry-in is slice k-1's registered carry-out. Slice 0 uses the effective carry-in (cin ^ sub).
- Skew and deskew:
  - Operand bits for slice k are delayed k stages on input.
  - Result bits of slice k are delayed P-1-k stages on output.
  - All bits of one result therefore leave together.
- Latency: exactly P cycles from an accepted input beat (in_valid && in_ready at edge t) to out_valid asserted after edge t+P-1, provided no stall occurs. Throughput is 1 beat/cycle.
- Handshake:
  - Global stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, all pipeline registers hold and in_ready=0.
  - A bubble (in_valid=0 while advance=1) propagates as valid=0.
  - out, cout and v stay stable while out_valid && !out_ready.
  - Inputs are ignored when in_valid=0.
- Reset values: out_valid=0, out=0, cout=0, v=0, all internal valid and data registers cleared. in_ready=1 after reset.
- Reset mid-operation: all in-flight beats are discarded with no partial result emitted. The first valid output after reset release comes from a beat accepted after release.
- Boundary cases:
  - P=1: single register stage on the output.
  - P=M/R: one carry-select block per slice.
  - Simultaneous accept and emit in one cycle is legal and required for full throughput.
  - out_ready held 0 with a full pipeline: exactly P beats are held, and none is dropped or duplicated.

Optional Feature:
- Macro: PIPE_ADDSUB_SAT_EN.
- When defined:
  - Extra input port sat (1 bit), sampled and carried with its beat.
  - When sat=1 and v=1, out is clamped to 0x7FF..F if the true result is positive (a[M-1]=0), else to 0x800..0.
  - v and cout still report the unsaturated flags.
  - Latency is unchanged; the clamp is a mux in the final stage.
- When not defined: no sat port, and the raw wrap-around result is output.

Decomposition:
- Package addsub_pkg holds:
  - parameter checks as constants: SLICE_W = M/P, BLOCKS_PER_SLICE = SLICE_W/R;
  - typedef addsub_op_t (enum ADD=0, SUB=1);
  - struct addsub_flags_t {cout, v}.
- Sub-module carry_select_slice (params W, R; ports cin, a, b, sum, cout). It is purely combinational and instantiated P times with generate.
- Skew/deskew shift registers stay in the top module.

Test Plan:
- M=32, P=4, add, x=0x7FFFFFFF, y=0x00000001, cin=0 -> 4 cycles later out=0x80000000, cout=0, v=1; with SAT_EN and sat=1 -> out=0x7FFFFFFF, v=1.
- Sub, x=0x00000000, y=0x00000001, cin=0 -> out=0xFFFFFFFF, cout=0, v=0. Sub, x=0x80000000, y=1, cin=0 -> out=0x7FFFFFFF, cout=1, v=1.
- Carry across slices and blocks: add, x=0xFFFFFFFF, y=0, cin=1 -> out=0x00000000, cout=1, v=0. Result is identical for every legal (R,P) such as (4,1), (4,8), (8,4).
- Back-to-back stream with out_ready toggling 1,0,0,1 over 64 random beats -> the output sequence equals a reference model in order, with no loss or duplication and out held stable during stalls.
- Fill the pipeline with out_ready=0 -> in_ready drops after P beats. Release -> one result per cycle.
- Assert rst_n=0 mid-stream for 1 cycle (asynchronously, between edges) -> out_valid=0 and out=0 immediately. No stale beats appear after release.
- Exhaustive stride sweep (x,y step 0x3FFFFF, both sub values, both cin values) against the behavioural expression -> zero mismatches.

Source files
------------

// File: rtl/pipelined_carry_select_add_sub_pkg.sv
// addsub_pkg: shared types and default geometry for the pipelined carry-select add/sub.
package addsub_pkg;
  localparam int DEF_M = 32;
  localparam int DEF_R = 4;
  localparam int DEF_P = 4;
  localparam int SLICE_W = DEF_M / DEF_P;
  localparam int BLOCKS_PER_SLICE = SLICE_W / DEF_R;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} addsub_op_t;
  typedef struct packed {
    logic cout;
    logic v;
  } addsub_flags_t;
endpackage

// File: rtl/pipelined_carry_select_add_sub_slice.sv
// carry_select_slice: combinational W-bit adder made of R-bit carry-select blocks.
module carry_select_slice #(
  parameter int W = 8,
  parameter int R = 4
) (
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int N = W / R;
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_blk
    logic [R:0] s0, s1;
    assign s0 = {1'b0, a[i*R +: R]} + {1'b0, b[i*R +: R]};
    assign s1 = {1'b0, a[i*R +: R]} + {1'b0, b[i*R +: R]} + {{R{1'b0}}, 1'b1};
    assign sum[i*R +: R] = c[i] ? s1[R-1:0] : s0[R-1:0];
    assign c[i+1] = c[i] ? s1[R] : s0[R];
  end
  assign cout = c[N];
endmodule

// File: rtl/pipelined_carry_select_add_sub.sv
// pipelined_carry_select_add_sub: P-slice pipelined add/sub with a valid/ready stream.
// Define PIPE_ADDSUB_SAT_EN to add the per-beat saturation input sat.
module pipelined_carry_select_add_sub
  import addsub_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int R = DEF_R,
  parameter int P = DEF_P
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         cin,
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
`ifdef PIPE_ADDSUB_SAT_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out,
  output logic         cout,
  output logic         v
);
  localparam int W = M / P;
  addsub_op_t op;
  logic advance, c_in;
  logic [M-1:0] b_in;
  assign op = addsub_op_t'(sub);
  assign b_in = (op == SUB) ? ~y : y;
  assign c_in = cin ^ sub;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  // Stage s owns slice s: it carries the not-yet-added operand bits forward
  // and accumulates the finished low result bits, so a beat leaves whole.
  for (genvar s = 0; s < P; s++) begin : g_st
    logic [M-1:s*W] opa, opb;
    logic [W-1:0] sum;
    logic [(s+1)*W-1:0] raw, res_d, res_q;
    logic ci, co, vin, vld_q;
`ifdef PIPE_ADDSUB_SAT_EN
    logic si;
`endif
    if (s == 0) begin : g_head
      assign opa = x;
      assign opb = b_in;
      assign ci = c_in;
      assign vin = in_valid;
      assign raw = sum;
`ifdef PIPE_ADDSUB_SAT_EN
      assign si = sat;
`endif
    end else begin : g_body
      assign opa = g_st[s-1].g_fwd.a_q;
      assign opb = g_st[s-1].g_fwd.b_q;
      assign ci = g_st[s-1].g_fwd.c_q;
      assign vin = g_st[s-1].vld_q;
      assign raw = {sum, g_st[s-1].res_q};
`ifdef PIPE_ADDSUB_SAT_EN
      assign si = g_st[s-1].g_fwd.sat_q;
`endif
    end
    carry_select_slice #(.W(W), .R(R)) u_slice (
      .cin (ci),
      .a   (opa[s*W +: W]),
      .b   (opb[s*W +: W]),
      .sum (sum),
      .cout(co)
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vld_q <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        vld_q <= vin;
        if (vin) res_q <= res_d;
      end
    if (s < P - 1) begin : g_fwd
      logic [M-1:(s+1)*W] a_q, b_q;
      logic c_q;
`ifdef PIPE_ADDSUB_SAT_EN
      logic sat_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sat_q <= 1'b0;
        else if (advance && vin) sat_q <= si;
`endif
      assign res_d = raw;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (advance && vin) begin
          a_q <= opa[M-1:(s+1)*W];
          b_q <= opb[M-1:(s+1)*W];
          c_q <= co;
        end
    end else begin : g_last
      addsub_flags_t flags_d, flags_q;
      assign flags_d = {co, (opa[M-1] == opb[M-1]) && (sum[W-1] != opa[M-1])};
`ifdef PIPE_ADDSUB_SAT_EN
      assign res_d = (si && flags_d.v) ? {opa[M-1], {(M-1){~opa[M-1]}}} : raw;
`else
      assign res_d = raw;
`endif
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) flags_q <= '0;
        else if (advance && vin) flags_q <= flags_d;
    end
  end
  assign out_valid = g_st[P-1].vld_q;
  assign out = g_st[P-1].res_q;
  assign {cout, v} = g_st[P-1].g_last.flags_q;
endmodule
